spiflash: RTL and testbench
===========================

# spiflash

Read-only SPI NOR flash controller exposing the SoC's valid/ready memory-bus slave interface. A bus read is translated into a single-IO READ (0x03) transaction: 8 command bits, 24 address bits, 32 data bits. The 32-bit word is returned on `mem_rdata`. It sits between the SoC memory interconnect and the external flash pins and drives `flash_cs`/`flash_clk` for the top level.

## Interface
- `CLK_DIV`, default 2: `clk` cycles per SCK half-period; must be ≥1.
- `CS_HIGH`, default 4: minimum `clk` cycles `flash_cs` stays high between transactions; must be ≥1.
- `clk  in  1`: sole clock.
- `reset  in  1`: asynchronous, active-low reset.
- `mem_valid  in  1`: request; held by the master until `mem_ready`.
- `mem_ready  out  1`: one-cycle completion pulse.
- `mem_addr  in  32`: byte address; bits [23:2] are used, other bits are ignored.
- `mem_wstrb  in  4`: nonzero marks a write; the write is acknowledged and discarded.
- `mem_rdata  out  32`: read data, valid while `mem_ready`=1.
- `flash_cs  out  1`: chip select, active-low.
- `flash_clk  out  1`: SCK in SPI mode 0; idles low.
- `flash_mosi  out  1`: drives flash IO0.
- `flash_miso  in  1`: from flash IO1.
- `flash_wp_n`, `flash_hold_n  out  1 each`: tied high; the top level drives IO2/IO3 with them.

## Operation
- States: `IDLE`, `SHIFT`, `DONE`, `GAP`.
- `IDLE`:
  - `mem_valid`=1 with `mem_wstrb`≠0 → `DONE`, with no flash activity.
  - `mem_valid`=1 with `mem_wstrb`=0 → latch the 64-bit shift word {0x03, mem_addr[23:2], 2'b00, 32'h0} → `SHIFT`.
- `SHIFT`:
  - `flash_cs`=0 for the whole state.
  - 64 SCK periods.
  - `flash_mosi` updates on each SCK falling edge; the first bit is presented on CS assertion. Bits go out MSB-first.
  - `flash_miso` is sampled on SCK rising edges during bits 32..63.
  - After the 64th rising edge the state waits one more half-period (SCK low) → `DONE`.
- `DONE`:
  - `mem_ready`=1 for one cycle and `flash_cs`=1, then → `GAP`.
  - Writes go `DONE` → `IDLE` directly.
- `GAP`: wait `CS_HIGH`−1 cycles → `IDLE`.
- Byte order is little-endian: the first received byte maps to `mem_rdata[7:0]` and the fourth to `mem_rdata[31:24]`.
- `mem_valid` is sampled only in `IDLE`. A request arriving during `GAP` waits.
- If `mem_valid` drops mid-transaction (a protocol violation), the transaction still completes and the ready pulse is still emitted.
- Reset asserted at any time, including mid-`SHIFT`:
  - Immediately: `flash_cs`=1, `flash_clk`=0, `flash_mosi`=0, `mem_ready`=0, `mem_rdata`=0, state `IDLE`.
  - Any transaction in progress is abandoned.

## Timing
- Uncached read accepted in `IDLE` at cycle N:
  - `flash_cs` falls at N+1.
  - `mem_ready` at N+2+128·`CLK_DIV`; `flash_cs` rises in that same cycle.
- Write accepted at cycle N: `mem_ready` at N+1.
- Back-to-back reads:
  - Next acceptance no earlier than the cycle after `GAP` ends.
  - CS-high time is ≥`CS_HIGH` cycles.
- SCK period is 2·`CLK_DIV` cycles with 50% duty.

## Configuration
- `SPIFLASH_CACHE_EN` defined:
  - A one-entry cache holds {valid, addr[23:2], data}.
  - A read hit in `IDLE` at cycle N returns the cached data with `mem_ready` at N+1, with no flash activity and no `GAP`.
  - Every completed flash read refills the entry.
  - Reset clears the valid bit.
  - Writes do not affect the entry.
- Undefined: every read goes to flash and the cache logic is absent.

## Structure
- Shared package `littlesoc_pkg`:
  - `SPI_CMD_READ` = 8'h03.
  - State enum `spiflash_state_t`.
  - Shift-frame length constants: 8/24/32.
- Sub-module `spiflash_shift`:
  - Contains the SCK divider, 64-bit MSB-first shifter and bit counter.
  - Start/done handshake.
  - The parent owns the state machine, bus handshake, byte swap and cache.

## Test plan
- Reset held low mid-`SHIFT` (bit 20) → within the same cycle `flash_cs`=1 and `flash_clk`=0. After release, the next read completes normally.
- `CLK_DIV`=2, flash model holds bytes 11 22 33 44 at 0x000100; read `mem_addr`=0x00000100 → MOSI carries 0x03,0x00,0x01,0x00. `mem_rdata`=0x44332211 with `mem_ready` exactly 258 cycles after acceptance.
- `mem_addr`=0xFF000103 → flash sees address 0x000100; bits [31:24] and [1:0] are ignored.
- Write with `mem_wstrb`=4'hF → `mem_ready` next cycle, `flash_cs` never falls, flash contents unchanged.
- Two back-to-back reads with `mem_valid` held → `flash_cs` high for ≥`CS_HIGH` cycles between them, and both data values are correct.
- With `SPIFLASH_CACHE_EN`, repeat a read of 0x100 → second `mem_ready` one cycle after acceptance, no SCK edges. A read of 0x104 then goes to flash.

Source files
------------

// File: rtl/littlesoc_pkg.sv
// Shared definitions for the littlesoc SPI flash read path.
package littlesoc_pkg;

  localparam logic [7:0] SPI_CMD_READ   = 8'h03;
  localparam int         SPI_CMD_BITS   = 8;
  localparam int         SPI_ADDR_BITS  = 24;
  localparam int         SPI_DATA_BITS  = 32;
  localparam int         SPI_FRAME_BITS = SPI_CMD_BITS + SPI_ADDR_BITS + SPI_DATA_BITS;

  typedef enum logic [1:0] {IDLE, SHIFT, DONE, GAP} spiflash_state_t;

  // Flash returns the lowest-addressed byte first; the bus is little-endian.
  function automatic logic [31:0] bswap32(input logic [31:0] w);
    return {w[7:0], w[15:8], w[23:16], w[31:24]};
  endfunction

endpackage

// File: rtl/spiflash_shift.sv
// SCK generator, 64-bit MSB-first frame shifter and bit counter (SPI mode 0).
// start loads the frame; done pulses once, one cycle after the last SCK fall.
module spiflash_shift
  import littlesoc_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [63:0] word,
  input  logic        miso,
  output logic        sck,
  output logic        mosi,
  output logic [31:0] rx,
  output logic        done
);

  localparam int HW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int NH = 2 * SPI_FRAME_BITS;          // half-periods per frame
  localparam int PW = $clog2(NH);
  localparam int RX_FIRST = 2 * (SPI_CMD_BITS + SPI_ADDR_BITS);

  logic          busy, last;
  logic [HW-1:0] hcnt;
  logic [PW-1:0] ph;       // half-period index; odd = SCK high
  logic [63:0]   sr;

  // Half-period timing, SCK edges, shifting out on falls and sampling on rises.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      busy <= 1'b0;
      last <= 1'b0;
      hcnt <= '0;
      ph   <= '0;
      sck  <= 1'b0;
      sr   <= '0;
      rx   <= '0;
    end else if (start) begin
      busy <= 1'b1;
      last <= 1'b0;
      hcnt <= '0;
      ph   <= '0;
      sck  <= 1'b0;
      sr   <= word;
    end else if (last) begin
      last <= 1'b0;
      busy <= 1'b0;
    end else if (busy) begin
      if (hcnt == HW'(CLK_DIV - 1)) begin
        hcnt <= '0;
        if (ph == PW'(NH - 1)) begin
          sck  <= 1'b0;     // final fall; SCK then stays low for one cycle
          last <= 1'b1;
        end else begin
          ph <= ph + PW'(1);
          if (!ph[0]) begin
            sck <= 1'b1;
            if (ph >= PW'(RX_FIRST)) rx <= {rx[30:0], miso};
          end else begin
            sck <= 1'b0;
            sr  <= {sr[62:0], 1'b0};
          end
        end
      end else begin
        hcnt <= hcnt + HW'(1);
      end
    end
  end

  assign mosi = busy & sr[63];
  assign done = last;

endmodule

// File: rtl/spiflash.sv
// Read-only SPI NOR flash controller (READ 0x03, single IO) on a valid/ready bus.
// Optional one-entry read cache: define SPIFLASH_CACHE_EN.
module spiflash
  import littlesoc_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_HIGH = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_valid,
  output logic        mem_ready,
  input  logic [31:0] mem_addr,
  input  logic [3:0]  mem_wstrb,
  output logic [31:0] mem_rdata,
  output logic        flash_cs,
  output logic        flash_clk,
  output logic        flash_mosi,
  input  logic        flash_miso,
  output logic        flash_wp_n,
  output logic        flash_hold_n
);

  spiflash_state_t state, state_nxt;
  logic        is_wr, hit, start, sh_done, gap_pend;
  logic [31:0] rx, rdata_q;
  logic [15:0] gcnt;
  logic        unused_addr;

  assign is_wr       = |mem_wstrb;
  assign unused_addr = ^{mem_addr[31:24], mem_addr[1:0]};

`ifdef SPIFLASH_CACHE_EN
  logic        c_vld;
  logic [21:0] c_tag, tag_q;
  logic [31:0] c_data;

  assign hit = c_vld && (c_tag == mem_addr[23:2]);

  // Every completed flash read refills the single entry; writes never touch it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      c_vld <= 1'b0;
    end else begin
      if (start) tag_q <= mem_addr[23:2];
      if (sh_done) begin
        c_vld  <= 1'b1;
        c_tag  <= tag_q;
        c_data <= bswap32(rx);
      end
    end
  end
`else
  assign hit = 1'b0;
`endif

  assign start = (state == IDLE) && mem_valid && !is_wr && !hit;

  spiflash_shift #(.CLK_DIV(CLK_DIV)) u_shift (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .word  ({SPI_CMD_READ, mem_addr[23:2], 2'b00, 32'h0}),
    .miso  (flash_miso),
    .sck   (flash_clk),
    .mosi  (flash_mosi),
    .rx    (rx),
    .done  (sh_done)
  );

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state and bus/chip-select outputs.
  always_comb begin
    state_nxt = state;
    mem_ready = 1'b0;
    flash_cs  = 1'b1;
    case (state)
      IDLE:  if (mem_valid) state_nxt = (is_wr || hit) ? DONE : SHIFT;
      SHIFT: begin
        flash_cs = 1'b0;
        if (sh_done) state_nxt = DONE;
      end
      DONE: begin
        mem_ready = 1'b1;
        state_nxt = (gap_pend && CS_HIGH > 1) ? GAP : IDLE;
      end
      GAP:     if (gcnt == 16'(CS_HIGH - 2)) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Read data capture, CS-high gap counter, and whether this access used the flash.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gap_pend <= 1'b0;
      gcnt     <= '0;
      rdata_q  <= '0;
    end else begin
      if (state == IDLE && mem_valid) gap_pend <= start;
      gcnt <= (state == GAP) ? gcnt + 16'd1 : 16'd0;
      if (sh_done) rdata_q <= bswap32(rx);
`ifdef SPIFLASH_CACHE_EN
      else if (state == IDLE && mem_valid && !is_wr && hit) rdata_q <= c_data;
`endif
    end
  end

  assign mem_rdata    = rdata_q;
  assign flash_wp_n   = 1'b1;
  assign flash_hold_n = 1'b1;

endmodule

// File: tb/tb_spiflash.sv
// Randomized self-checking bench for spiflash with a behavioural flash and bus model.
module tb_spiflash;

  localparam int CLK_DIV  = 2;
  localparam int CS_HIGH  = 4;
  localparam int MISS_LAT = 2 + 128 * CLK_DIV;
`ifdef SPIFLASH_CACHE_EN
  localparam bit CACHE = 1'b1;
`else
  localparam bit CACHE = 1'b0;
`endif

  logic        clk = 1'b0, reset = 1'b1, mem_valid = 1'b0;
  logic [31:0] mem_addr = '0;
  logic [3:0]  mem_wstrb = '0;
  logic        mem_ready, flash_cs, flash_clk, flash_mosi, flash_wp_n, flash_hold_n;
  logic [31:0] mem_rdata;
  logic        flash_miso = 1'b0;

  always #5 clk = ~clk;

  spiflash #(.CLK_DIV(CLK_DIV), .CS_HIGH(CS_HIGH)) dut (
    .clk(clk), .reset(reset), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .flash_cs(flash_cs), .flash_clk(flash_clk), .flash_mosi(flash_mosi),
    .flash_miso(flash_miso), .flash_wp_n(flash_wp_n), .flash_hold_n(flash_hold_n)
  );

  int errors = 0, checks = 0, cyc = 0;
  always @(posedge clk) cyc++;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- flash device model (4 KB image, address wraps) ----------------
  logic [7:0]  fmem [0:4095];
  int          bitn = 0, cs_falls = 0, sck_rises = 0;
  logic [31:0] hdr;
  logic [7:0]  last_cmd;
  logic [23:0] last_addr;

  always @(negedge flash_cs) begin
    cs_falls++; bitn = 0; last_cmd = '0; last_addr = '1;
  end
  always @(posedge flash_clk) begin
    sck_rises++;
    if (flash_cs === 1'b0) begin
      if (bitn < 32) hdr = {hdr[30:0], flash_mosi};
      bitn++;
      if (bitn == 32) begin last_cmd = hdr[31:24]; last_addr = hdr[23:0]; end
    end
  end
  always @(negedge flash_clk) begin
    int d; logic [7:0] b;
    if (flash_cs === 1'b0 && bitn >= 32 && bitn < 64) begin
      d = bitn - 32;
      b = fmem[12'(last_addr + 24'(d / 8))];
      flash_miso = b[7 - d % 8];
    end
  end

  function automatic logic [31:0] ref_word(input logic [23:0] a);
    return {fmem[12'(a + 3)], fmem[12'(a + 2)], fmem[12'(a + 1)], fmem[12'(a)]};
  endfunction

  // ---------------- bus-level reference model ----------------
  typedef struct {
    bit          rd, fl;
    logic [31:0] data;
    logic [23:0] fa;
    int          lat, acc, falls0, rises0;
  } exp_t;
  exp_t        expq[$];
  bit          c_vld = 1'b0;
  logic [21:0] c_tag;
  logic [31:0] c_data;

  // One compare process: every cycle invariants, and each ready pulse against the model.
  bit chk_en = 1'b0, seen_low = 1'b0;
  int hi_run = 0;
  always @(negedge clk) begin
    exp_t e;
    if (chk_en) begin
      chk("wp_hold", 32'({flash_wp_n, flash_hold_n}), 32'h3);
      if (flash_cs === 1'b1) begin
        chk("sck_idle_low", 32'(flash_clk), 32'h0);
        hi_run++;
      end else begin
        if (seen_low && hi_run > 0) begin
          checks++;
          if (hi_run < CS_HIGH) begin
            errors++;
            $display("FAIL cs_high_time: got %0d cycles, need >= %0d", hi_run, CS_HIGH);
          end
        end
        seen_low = 1'b1; hi_run = 0;
      end
      if (mem_ready === 1'b1) begin
        if (expq.size() == 0) begin
          chk("unexpected_ready", 32'(mem_ready), 32'h0);
        end else begin
          e = expq.pop_front();
          if (e.lat >= 0) chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
          if (e.rd) chk("rdata", mem_rdata, e.data);
          if (e.fl) begin
            chk("flash_cmd", 32'(last_cmd), 32'h03);
            chk("flash_addr", 32'(last_addr), 32'(e.fa));
            chk("cs_falls", 32'(cs_falls - e.falls0), 32'd1);
          end else begin
            chk("no_cs_fall", 32'(cs_falls - e.falls0), 32'd0);
            chk("no_sck", 32'(sck_rises - e.rises0), 32'd0);
          end
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // mode 0: model; mode 1: hand-computed 0x100 expectation; mode 2: latency unchecked
  task automatic drive(input logic [31:0] a, input logic [3:0] ws, input int mode);
    exp_t e;
    bit   got;
    e.rd = (ws == 4'h0); e.fa = {a[23:2], 2'b00}; e.acc = cyc + 1;
    e.falls0 = cs_falls; e.rises0 = sck_rises; e.data = '0;
    if (!e.rd) begin
      e.fl = 1'b0; e.lat = 1;
    end else if (CACHE && c_vld && c_tag == a[23:2]) begin
      e.fl = 1'b0; e.lat = 1; e.data = c_data;
    end else begin
      e.fl = 1'b1; e.lat = MISS_LAT; e.data = ref_word(e.fa);
      c_vld = 1'b1; c_tag = a[23:2]; c_data = e.data;
    end
    if (mode == 1) begin e.data = 32'h44332211; e.lat = 258; end
    if (mode == 2) e.lat = -1;
    expq.push_back(e);
    mem_valid = 1'b1; mem_addr = a; mem_wstrb = ws;
    got = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (mem_ready === 1'b1) begin got = 1'b1; break; end
    end
    chk("ready_timeout", 32'(got), 32'h1);
    if (!got) expq.delete();
    @(posedge clk); #1;
  endtask

  task automatic single(input logic [31:0] a, input logic [3:0] ws, input int mode);
    drive(a, ws, mode);
    mem_valid = 1'b0; mem_wstrb = '0;
    idle(CS_HIGH + 2);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  logic [23:0] pool [0:5];
  initial begin
    bit got;
    logic [31:0] a;
    pool = '{24'h000000, 24'h000004, 24'h000100, 24'h0007F8, 24'h00AABC, 24'h000FFC};
    for (int i = 0; i < 4096; i++) fmem[i] = 8'($urandom);
    fmem[12'h100] = 8'h11; fmem[12'h101] = 8'h22; fmem[12'h102] = 8'h33; fmem[12'h103] = 8'h44;

    #1 reset = 1'b0;
    idle(3);
    chk("rst_cs", 32'(flash_cs), 32'h1);
    chk("rst_clk", 32'(flash_clk), 32'h0);
    chk("rst_mosi", 32'(flash_mosi), 32'h0);
    chk("rst_ready", 32'(mem_ready), 32'h0);
    chk("rst_rdata", mem_rdata, 32'h0);
    reset = 1'b1; chk_en = 1'b1;
    idle(CS_HIGH + 2);

    single(32'h0000_0100, 4'h0, 1);      // 0x44332211 after 258 cycles
    single(32'h0000_0100, 4'hF, 0);      // write: ready next cycle, no flash activity
    single(32'h0000_0200, 4'h0, 0);
    single(32'hFF00_0103, 4'h0, 0);      // flash must see 0x000100
    single(32'h0000_0100, 4'h0, 0);      // cache hit when enabled
    single(32'h0000_0104, 4'h0, 0);      // always a flash read

    drive(32'h0000_0208, 4'h0, 0);       // back-to-back, valid held
    drive(32'h0000_030C, 4'h0, 2);
    mem_valid = 1'b0;
    idle(CS_HIGH + 2);

    // Reset in the middle of a shift
    mem_valid = 1'b1; mem_addr = 32'h0000_0300; mem_wstrb = '0;
    got = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (flash_cs === 1'b0 && bitn >= 20) begin got = 1'b1; break; end
    end
    chk("reach_bit20", 32'(got), 32'h1);
    #2 reset = 1'b0; chk_en = 1'b0;
    #1;
    chk("midrst_cs", 32'(flash_cs), 32'h1);
    chk("midrst_clk", 32'(flash_clk), 32'h0);
    chk("midrst_mosi", 32'(flash_mosi), 32'h0);
    chk("midrst_ready", 32'(mem_ready), 32'h0);
    chk("midrst_rdata", mem_rdata, 32'h0);
    mem_valid = 1'b0; expq.delete(); c_vld = 1'b0;
    idle(3);
    reset = 1'b1; hi_run = 0; seen_low = 1'b0; chk_en = 1'b1;
    idle(CS_HIGH + 2);
    single(32'h0000_0300, 4'h0, 0);

    // Randomized traffic over a small address pool so cache hits occur
    for (int n = 0; n < 40; n++) begin
      a = {8'($urandom), pool[$urandom_range(0, 5)]};
      a[1:0] = 2'($urandom);
      if ($urandom_range(0, 7) == 0) a[23:2] = 22'($urandom);
      if ($urandom_range(0, 3) == 0) single(a, 4'($urandom_range(1, 15)), 0);
      else                           single(a, 4'h0, 0);
      idle($urandom_range(0, 3));
    end

    idle(5);
    chk("pending_expectations", 32'(expq.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
